// File: rtl/mealy_decoder.sv
// Receive-side decoder for the 4-state Mealy bit-stream encoder: tracks the
// encoder state from the z stream, recovers x, and packs x bits LSB-first into words.
module mealy_decoder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             zIn,
  input  logic             zValid,
  input  logic             clear,
  output logic             xOut,
  output logic             xValid,
  output logic [1:0]       state,
  output logic [WIDTH-1:0] wordOut,
  output logic             wordValid
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } state_e;

  state_e           state_q, state_d, state_nxt;
  logic             x_dec;
  logic             xOut_q, xOut_d;
  logic             xValid_q, xValid_d;
  logic             wordValid_q, wordValid_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [WIDTH-1:0] assembled;
  logic [CW-1:0]    cnt_q, cnt_d;

  // S0 and S3 emit the complement of x; S1 and S2 emit x unchanged.
  always_comb begin
    x_dec = zIn ^ ((state_q == S0) || (state_q == S3));
  end

  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      S0: state_nxt = x_dec ? S2 : S1;
      S1: state_nxt = x_dec ? S3 : S2;
      S2: state_nxt = x_dec ? S3 : S1;
      S3: state_nxt = x_dec ? S0 : S2;
      default: state_nxt = S0;
    endcase
  end

  // Partial word with the current decoded bit dropped in at position cnt_q.
  always_comb begin
    assembled = shift_q;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (cnt_q == CW'(i)) assembled[i] = x_dec;
    end
  end

  always_comb begin
    state_d     = state_q;
    xOut_d      = xOut_q;
    xValid_d    = 1'b0;
    wordValid_d = 1'b0;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    word_d      = word_q;
    if (clear) begin
      state_d = S0;
      cnt_d   = '0;
      shift_d = '0;
    end else if (zValid) begin
      xOut_d   = x_dec;
      xValid_d = 1'b1;
      state_d  = state_nxt;
      if (cnt_q == CW'(WIDTH - 1)) begin
        word_d      = assembled;
        wordValid_d = 1'b1;
        cnt_d       = '0;
        shift_d     = '0;
      end else begin
        shift_d = assembled;
        cnt_d   = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S0;
      xOut_q      <= 1'b0;
      xValid_q    <= 1'b0;
      wordValid_q <= 1'b0;
      shift_q     <= '0;
      cnt_q       <= '0;
      word_q      <= '0;
    end else begin
      state_q     <= state_d;
      xOut_q      <= xOut_d;
      xValid_q    <= xValid_d;
      wordValid_q <= wordValid_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      word_q      <= word_d;
    end
  end

  assign xOut      = xOut_q;
  assign xValid    = xValid_q;
  assign state     = state_q;
  assign wordOut   = word_q;
  assign wordValid = wordValid_q;

endmodule

// File: tb/tb_mealy_decoder.sv
// Scoreboard bench for mealy_decoder: a table-driven encoder model predicts x,
// state and words for WIDTH=8 and WIDTH=1 instances fed the same stream.
module tb_mealy_decoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic zIn = 1'b0, zValid = 1'b0, clear = 1'b0;

  logic       x8, xv8, wv8;
  logic [1:0] st8;
  logic [7:0] w8;
  logic       x1, xv1, wv1;
  logic [1:0] st1;
  logic [0:0] w1;

  mealy_decoder #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .zIn(zIn), .zValid(zValid), .clear(clear),
    .xOut(x8), .xValid(xv8), .state(st8), .wordOut(w8), .wordValid(wv8)
  );

  mealy_decoder #(.WIDTH(1)) u1 (
    .clk(clk), .rst(rst), .zIn(zIn), .zValid(zValid), .clear(clear),
    .xOut(x1), .xValid(xv1), .state(st1), .wordOut(w1), .wordValid(wv1)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          x;
    int          st;
    int          cyc;
    bit          wv;
    logic [31:0] w;
  } exp_t;

  exp_t q8[$];
  exp_t q1[$];
  exp_t e8, e1;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Encoder tables indexed [state][x]
  int enc_next [4][2];
  bit enc_z    [4][2];

  int          mstate;
  int          n8;
  logic [31:0] acc8;
  logic [31:0] last8, last1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit model_x(input int s, input bit z);
    for (int x = 0; x < 2; x++) if (enc_z[s][x] == z) return bit'(x);
    return 1'b0;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  task automatic drive(input bit z, input bit v, input bit c);
    exp_t e;
    bit   xb;
    int   ns;
    @(negedge clk);
    zIn = z; zValid = v; clear = c;
    if (c) begin
      mstate = 0; n8 = 0; acc8 = '0;
    end else if (v) begin
      xb = model_x(mstate, z);
      ns = enc_next[mstate][xb];
      acc8[n8] = xb;
      n8++;
      e.x = xb; e.st = ns; e.cyc = cyc + 1;
      e.wv = (n8 == 8); e.w = acc8;
      if (e.wv) begin n8 = 0; acc8 = '0; end
      q8.push_back(e);
      e.wv = 1'b1; e.w = {31'b0, xb};
      q1.push_back(e);
      mstate = ns;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    zValid = 1'b0; clear = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_x8", 32'(x8), 0);   chk("rst_xv8", 32'(xv8), 0);
    chk("rst_st8", 32'(st8), 0); chk("rst_w8", 32'(w8), 0);
    chk("rst_wv8", 32'(wv8), 0);
    chk("rst_x1", 32'(x1), 0);   chk("rst_st1", 32'(st1), 0);
    chk("rst_w1", 32'(w1), 0);   chk("rst_wv1", 32'(wv1), 0);
    mstate = 0; n8 = 0; acc8 = '0; last8 = '0; last1 = '0;
    q8.delete(); q1.delete();
    #1 rst = 1'b0;
  endtask

  task automatic stream_a(input int gap_after, input int gap_len);
    bit [7:0] za;
    za = 8'b1100_0101;
    for (int i = 0; i < 8; i++) begin
      drive(za[i], 1'b1, 1'b0);
      if (i + 1 == gap_after)
        for (int g = 0; g < gap_len; g++) drive(1'b0, 1'b0, 1'b0);
    end
    drive(1'b0, 1'b0, 1'b0);
    @(posedge clk); #2;
    chk("streamA_word", 32'(w8), 32'h5C);
  endtask

  always @(posedge clk) begin
    #1;
    if (xv8) begin
      if (q8.size() == 0) chk("w8_spurious_xvalid", 1, 0);
      else begin
        e8 = q8.pop_front();
        chk("w8_latency", cyc, e8.cyc);
        chk("w8_xOut", 32'(x8), 32'(e8.x));
        chk("w8_state", 32'(st8), e8.st);
        chk("w8_wordValid", 32'(wv8), 32'(e8.wv));
        if (e8.wv) last8 = e8.w;
      end
    end else begin
      chk("w8_wordValid_idle", 32'(wv8), 0);
      if (q8.size() > 0 && q8[0].cyc <= cyc) begin
        chk("w8_missing_xvalid", 0, 1);
        q8.delete(0);
      end
    end
    chk("w8_wordOut", 32'(w8), last8);
  end

  always @(posedge clk) begin
    #1;
    if (xv1) begin
      if (q1.size() == 0) chk("w1_spurious_xvalid", 1, 0);
      else begin
        e1 = q1.pop_front();
        chk("w1_latency", cyc, e1.cyc);
        chk("w1_xOut", 32'(x1), 32'(e1.x));
        chk("w1_state", 32'(st1), e1.st);
        chk("w1_wordValid", 32'(wv1), 32'(e1.wv));
        if (e1.wv) last1 = e1.w;
      end
    end else begin
      chk("w1_wordValid_idle", 32'(wv1), 0);
      if (q1.size() > 0 && q1[0].cyc <= cyc) begin
        chk("w1_missing_xvalid", 0, 1);
        q1.delete(0);
      end
    end
    chk("w1_wordOut", 32'(w1), last1);
  end

  initial begin
    enc_next = '{'{1, 2}, '{2, 3}, '{1, 3}, '{2, 0}};
    enc_z    = '{'{1, 0}, '{0, 1}, '{0, 1}, '{1, 0}};
    mstate = 0; n8 = 0; acc8 = '0; last8 = '0; last1 = '0;

    do_reset();
    stream_a(0, 0);

    do_reset();
    stream_a(3, 3);

    // Constant zero input: word 0x01, then a partial word abandoned by clear+valid
    do_reset();
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b1);
    @(posedge clk); #2;
    chk("clear_state", 32'(st8), 0);
    chk("clear_xValid", 32'(xv8), 0);
    chk("clear_wordOut_hold", 32'(w8), 32'h01);
    stream_a(0, 0);

    // Asynchronous reset mid-word, then resume
    do_reset();
    for (int i = 0; i < 5; i++) drive(1'(i & 1), 1'b1, 1'b0);
    do_reset();
    stream_a(0, 0);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) < 2) do_reset();
      else drive(1'($urandom_range(0, 1)), $urandom_range(0, 99) < 75,
                 $urandom_range(0, 99) < 3);
    end

    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0);
    @(posedge clk); #2;
    chk("drain_q8", q8.size(), 0);
    chk("drain_q1", q1.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mealy_decoder.md
Name: mealy_decoder

Overview:
- Receive-side inverse of the team's 4-state Mealy bit-stream encoder (states S0..S3, input bit x, output bit z).
- Tracks the encoder's state from the received z stream and recovers the original x bit each valid cycle.
- Packs recovered bits into WIDTH-bit words with a one-cycle word strobe for downstream logic.
- Sits directly after the encoder's z output, or after a link carrying it. Encoder and decoder both start in S0.

Parameters:
WIDTH, 8, number of decoded bits per assembled word (legal range 1..32)

Ports:
clk  input  1  system clock; all state changes on its rising edge
rst  input  1  asynchronous, active-high reset
zIn  input  1  received encoded bit
zValid  input  1  zIn carries a valid bit this cycle
clear  input  1  synchronous resynchronise: force state S0 and discard any partial word
xOut  output  1  recovered original bit (registered)
xValid  output  1  one-cycle pulse: xOut updated this cycle
state  output  2  current tracked encoder state (S0=00, S1=01, S2=10, S3=11)
wordOut  output  WIDTH  last completed word; first received bit in bit 0 (LSB-first)
wordValid  output  1  one-cycle pulse: wordOut updated this cycle

Behaviour:
- Reset (rst=1, asynchronous) forces:
  - state=S0, xOut=0, xValid=0, wordOut=0, wordValid=0.
  - Internal shift register and bit counter cleared.
  - Applies immediately, including mid-word; the partial word is lost.
- Decode function. The encoder maps x to z per state as follows:
  - S0: x0→z1, next S1; x1→z0, next S2.
  - S1: x0→z0, next S2; x1→z1, next S3.
  - S2: x0→z0, next S1; x1→z1, next S3.
  - S3: x0→z1, next S2; x1→z0, next S0.
  - Decoder inverse: x = zIn XOR inv, where inv=1 in S0 and S3, inv=0 in S1 and S2.
  - Next state is computed from (state, decoded x) using the encoder transition table above.
- Each rising edge with clear=0 and zValid=1:
  - xOut <= decoded x; xValid <= 1; state <= next state.
  - Decoded x shifts into the word at position bitCount; bitCount increments.
  - Latency is exactly one clock from zIn sampled to xOut/xValid.
- Edge with zValid=0: state, xOut, shift register and bitCount hold; xValid <= 0; wordValid <= 0.
- Word completion: when the bit written is the WIDTH-th bit (bitCount == WIDTH-1 before the edge):
  - wordOut <= full assembled word including that bit; wordValid <= 1 on the same edge as its xValid.
  - bitCount <= 0.
  - WIDTH=1 produces wordValid with every xValid.
- wordOut holds its value until the next completed word; wordValid is high for exactly one cycle per word.
- clear=1 at an edge (synchronous):
  - state <= S0; bitCount <= 0; shift register <= 0; xValid <= 0; wordValid <= 0.
  - xOut and wordOut hold.
  - clear wins over a simultaneous zValid=1: that bit is discarded and not decoded.
- bitCount width is $clog2(WIDTH+1). It never exceeds WIDTH-1 between words.
- Unused high shift-register bits (none when the register is sized exactly WIDTH) read 0.
- No error detection: every (state, z) pair decodes to a legal x. Loss of sync is recovered only by clear or rst.

Test Plan:
- Reset then zValid=1 for 8 cycles, zIn = 1,0,1,0,0,0,1,1 → xOut per cycle = 0,0,1,1,1,0,1,0; state sequence after each bit = S1,S2,S3,S0,S2,S1,S3,S2; wordValid pulses once on the 8th xValid with wordOut=0x5C.
- Same stream with zValid dropped for 3 cycles after bit 3 → identical xOut sequence, state, and wordOut=0x5C; xValid low during the gap; wordValid delayed by exactly 3 cycles.
- From reset, zIn=0 constant with zValid=1 for 4 cycles → xOut = 1,0,0,0; state = S2,S1,S2,S1.
- Assert rst asynchronously (mid-cycle) after 5 valid bits → all outputs 0 and state=S0 immediately. The next 8 bits from the first scenario again yield wordOut=0x5C.
- clear=1 together with zValid=1 after 4 bits → that bit ignored, xValid=0, state=S0, bitCount=0. A following 8-bit stream decodes as from reset; wordOut keeps its prior value until the new word completes.
- WIDTH=1 instance, zIn=1,0 → wordOut = 0 then 0, with wordValid coincident with every xValid.
